// File: rtl/video_pkg.sv
// Shared definitions for the synthetic video pattern source: pattern codes,
// FSM state encoding and the colour-bar lookup.
package video_pkg;

  // Pattern selection codes
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_EDGE  = 2'd3;

  // Line/frame sequencing states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_t;

  // Colour bar channel enables, {r, g, b}: each channel is either full scale or 0
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;

  // Bar index (left to right) to channel enables
  function automatic logic [2:0] bar_flags(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_flags = BAR_WHITE;
      3'd1:    bar_flags = BAR_YELLOW;
      3'd2:    bar_flags = BAR_CYAN;
      3'd3:    bar_flags = BAR_GREEN;
      3'd4:    bar_flags = BAR_MAGENTA;
      3'd5:    bar_flags = BAR_RED;
      3'd6:    bar_flags = BAR_BLUE;
      default: bar_flags = BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_pattern_src_if.sv
// RGB pixel stream between the pattern source (master) and the
// image-processing pipeline (slave).
interface video_pattern_src_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rgb_valid;
  logic                  rgb_hsync;
  logic                  rgb_vsync;
  logic [DATA_WIDTH-1:0] r;
  logic [DATA_WIDTH-1:0] g;
  logic [DATA_WIDTH-1:0] b;

  modport master (
    output rgb_valid, rgb_hsync, rgb_vsync, r, g, b
  );

  modport slave (
    input rgb_valid, rgb_hsync, rgb_vsync, r, g, b
  );
endinterface

// File: rtl/video_pattern_colour.sv
// Combinational pixel colour generator: maps (pattern, x, y, bar index) to
// r/g/b. Blanking is applied by the caller.
module video_pattern_colour
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int CHECK_LOG2 = 3,
  parameter int XW         = 10,
  parameter int YW         = 10
) (
  input  logic [1:0]            pattern,
  input  logic [XW-1:0]         x,
  input  logic [YW-1:0]         y,
  input  logic [2:0]            bar_idx,
  output logic [DATA_WIDTH-1:0] r,
  output logic [DATA_WIDTH-1:0] g,
  output logic [DATA_WIDTH-1:0] b
);

  localparam logic [DATA_WIDTH-1:0] MAXV   = '1;
  localparam logic [XW-1:0]         X_HALF = XW'(H_ACTIVE / 2);

  logic                  x_bit;
  logic                  y_bit;
  logic                  use_ramp;
  logic [2:0]            on_flags;
  logic [DATA_WIDTH-1:0] ramp;
  logic [DATA_WIDTH-1:0] chan [3];

  // Checkerboard square selectors; shifting keeps this valid when the
  // square size exceeds the counter width
  assign x_bit = |((x >> CHECK_LOG2) & XW'(1));
  assign y_bit = |((y >> CHECK_LOG2) & YW'(1));

  // Ramp wraps every 2^DATA_WIDTH pixels (truncation) or zero-extends
  assign ramp = DATA_WIDTH'(x);

  // Pattern decode into either a gray ramp or per-channel full/zero enables
  always_comb begin
    use_ramp = 1'b0;
    on_flags = BAR_BLACK;
    case (pattern)
      PAT_BARS:  on_flags = bar_flags(bar_idx);
      PAT_RAMP:  use_ramp = 1'b1;
      PAT_CHECK: on_flags = {3{x_bit ^ y_bit}};
      PAT_EDGE:  on_flags = {3{x >= X_HALF}};
      default:   on_flags = BAR_BLACK;
    endcase
  end

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_chan
    assign chan[gi] = use_ramp ? ramp : (on_flags[gi] ? MAXV : '0);
  end

  assign r = chan[2];
  assign g = chan[1];
  assign b = chan[0];

endmodule

// File: rtl/video_pattern_src.sv
// Synthetic RGB video source: frames of H_ACTIVE x V_ACTIVE pixels with
// horizontal/vertical blanking and four selectable test patterns.
// Optional macro VIDEO_PATTERN_SRC_PIX_DIV2_EN: each beat spans two clock
// cycles; rgb_valid, pixel data and frame_done appear only on the first
// cycle of a beat, syncs hold for both cycles.
module video_pattern_src
  import video_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int H_BLANK    = 160,
  parameter int V_BLANK    = 45,
  parameter int CHECK_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst_p,
  input  logic                start,
  input  logic                continuous,
  input  logic [1:0]          pattern_sel,
  video_pattern_src_if.master vid,
  output logic                busy,
  output logic                frame_done
);

  localparam int H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int V_TOTAL = V_ACTIVE + V_BLANK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int BAR_W   = H_ACTIVE / 8;
  localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

  localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] BAR_LAST   = BW'(BAR_W - 1);

  // Sequencing state: counters describe the beat currently on the outputs
  state_t          state_reg, state_next;
  logic [HW-1:0]   h_cnt_reg, h_cnt_next;
  logic [VW-1:0]   v_cnt_reg, v_cnt_next;
  logic [BW-1:0]   bar_sub_reg, bar_sub_next;
  logic [2:0]      bar_idx_reg, bar_idx_next;
  logic [1:0]      pat_reg, pat_next;
  logic            armed_reg;
  logic            step;

  // Registered outputs and their next values
  logic                  valid_reg, valid_next;
  logic                  hsync_reg, hsync_next;
  logic                  vsync_reg, vsync_next;
  logic                  busy_reg, busy_next;
  logic                  frame_done_reg, frame_done_next;
  logic [DATA_WIDTH-1:0] r_reg, r_next;
  logic [DATA_WIDTH-1:0] g_reg, g_next;
  logic [DATA_WIDTH-1:0] b_reg, b_next;
  logic [DATA_WIDTH-1:0] col_r, col_g, col_b;

`ifdef VIDEO_PATTERN_SRC_PIX_DIV2_EN
  logic phase_reg;

  // Half-rate beat: a beat advances at the end of its second cycle; IDLE
  // reacts to start every cycle so the first pixel follows start directly
  assign step = (state_reg == ST_IDLE) || phase_reg;

  // Beat phase toggle, cleared whenever a beat boundary is taken
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      phase_reg <= 1'b0;
    end else begin
      phase_reg <= ~step;
    end
  end
`else
  assign step = 1'b1;
`endif

  // Next position in the frame: pixel/line counters, bar sub-counter, state
  always_comb begin
    state_next   = state_reg;
    h_cnt_next   = h_cnt_reg;
    v_cnt_next   = v_cnt_reg;
    bar_sub_next = bar_sub_reg;
    bar_idx_next = bar_idx_reg;
    pat_next     = pat_reg;
    case (state_reg)
      ST_IDLE: begin
        // armed_reg masks a start that coincides with reset release
        if (start && armed_reg) begin
          state_next   = ST_ACTIVE;
          h_cnt_next   = '0;
          v_cnt_next   = '0;
          bar_sub_next = '0;
          bar_idx_next = '0;
          pat_next     = pattern_sel;
        end
      end
      ST_ACTIVE: begin
        h_cnt_next = h_cnt_reg + 1'b1;
        if (h_cnt_reg == H_ACT_LAST) begin
          state_next = ST_HBLANK;
        end else if (bar_sub_reg == BAR_LAST) begin
          bar_sub_next = '0;
          bar_idx_next = bar_idx_reg + 3'd1;
        end else begin
          bar_sub_next = bar_sub_reg + 1'b1;
        end
      end
      ST_HBLANK: begin
        if (h_cnt_reg == H_LAST) begin
          h_cnt_next   = '0;
          v_cnt_next   = v_cnt_reg + 1'b1;
          bar_sub_next = '0;
          bar_idx_next = '0;
          state_next   = (v_cnt_reg == V_ACT_LAST) ? ST_VBLANK : ST_ACTIVE;
        end else begin
          h_cnt_next = h_cnt_reg + 1'b1;
        end
      end
      ST_VBLANK: begin
        if (h_cnt_reg == H_LAST) begin
          h_cnt_next = '0;
          if (v_cnt_reg == V_LAST) begin
            v_cnt_next   = '0;
            bar_sub_next = '0;
            bar_idx_next = '0;
            if (continuous) begin
              state_next = ST_ACTIVE;
              pat_next   = pattern_sel;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            v_cnt_next = v_cnt_reg + 1'b1;
          end
        end else begin
          h_cnt_next = h_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Colour for the upcoming position so the pixel registers line up with it
  video_pattern_colour #(
    .DATA_WIDTH (DATA_WIDTH),
    .H_ACTIVE   (H_ACTIVE),
    .CHECK_LOG2 (CHECK_LOG2),
    .XW         (HW),
    .YW         (VW)
  ) u_colour (
    .pattern (pat_next),
    .x       (h_cnt_next),
    .y       (v_cnt_next),
    .bar_idx (bar_idx_next),
    .r       (col_r),
    .g       (col_g),
    .b       (col_b)
  );

  // Output values for the upcoming beat; pixel data is forced to 0 in blanking
  always_comb begin
    valid_next      = (state_next == ST_ACTIVE);
    hsync_next      = (state_next == ST_ACTIVE);
    vsync_next      = (state_next == ST_ACTIVE) || (state_next == ST_HBLANK);
    busy_next       = (state_next != ST_IDLE);
    frame_done_next = (state_next == ST_VBLANK) && (h_cnt_next == H_LAST) &&
                      (v_cnt_next == V_LAST);
    r_next          = valid_next ? col_r : '0;
    g_next          = valid_next ? col_g : '0;
    b_next          = valid_next ? col_b : '0;
  end

  // State, counters and output registers; the second cycle of a half-rate
  // beat drops valid, pixel data and frame_done while syncs hold
  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state_reg      <= ST_IDLE;
      h_cnt_reg      <= '0;
      v_cnt_reg      <= '0;
      bar_sub_reg    <= '0;
      bar_idx_reg    <= '0;
      pat_reg        <= PAT_BARS;
      armed_reg      <= 1'b0;
      valid_reg      <= 1'b0;
      hsync_reg      <= 1'b0;
      vsync_reg      <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      r_reg          <= '0;
      g_reg          <= '0;
      b_reg          <= '0;
    end else begin
      armed_reg <= 1'b1;
      if (step) begin
        state_reg      <= state_next;
        h_cnt_reg      <= h_cnt_next;
        v_cnt_reg      <= v_cnt_next;
        bar_sub_reg    <= bar_sub_next;
        bar_idx_reg    <= bar_idx_next;
        pat_reg        <= pat_next;
        valid_reg      <= valid_next;
        hsync_reg      <= hsync_next;
        vsync_reg      <= vsync_next;
        busy_reg       <= busy_next;
        frame_done_reg <= frame_done_next;
        r_reg          <= r_next;
        g_reg          <= g_next;
        b_reg          <= b_next;
      end else begin
        valid_reg      <= 1'b0;
        frame_done_reg <= 1'b0;
        r_reg          <= '0;
        g_reg          <= '0;
        b_reg          <= '0;
      end
    end
  end

  assign vid.rgb_valid = valid_reg;
  assign vid.rgb_hsync = hsync_reg;
  assign vid.rgb_vsync = vsync_reg;
  assign vid.r         = r_reg;
  assign vid.g         = g_reg;
  assign vid.b         = b_reg;
  assign busy          = busy_reg;
  assign frame_done    = frame_done_reg;

endmodule

// File: tb/tb_video_pattern_src.sv
// Directed bench for video_pattern_src on a 16x4 frame (H_BLANK 4, V_BLANK 2,
// 2-pixel checker squares). Frames are captured with per-cycle timing checks,
// then pixels are compared against a table of hand-computed values.
module tb_video_pattern_src;
  localparam int DW = 8;
  localparam int HA = 16;
  localparam int VA = 4;
  localparam int HB = 4;
  localparam int VB = 2;
  localparam int CL = 1;
  localparam int HT = HA + HB;
  localparam int FRAME_BEATS = HT * (VA + VB);
`ifdef VIDEO_PATTERN_SRC_PIX_DIV2_EN
  localparam int DIV = 2;
`else
  localparam int DIV = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_p;
  logic       start;
  logic       continuous;
  logic [1:0] pattern_sel;
  logic       busy;
  logic       frame_done;

  video_pattern_src_if #(.DATA_WIDTH(DW)) vid ();

  video_pattern_src #(
    .DATA_WIDTH (DW),
    .H_ACTIVE   (HA),
    .V_ACTIVE   (VA),
    .H_BLANK    (HB),
    .V_BLANK    (VB),
    .CHECK_LOG2 (CL)
  ) dut (
    .clk         (clk),
    .rst_p       (rst_p),
    .start       (start),
    .continuous  (continuous),
    .pattern_sel (pattern_sel),
    .vid         (vid),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          slot;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vecs[$];
  logic [23:0] cap [7][HA*VA];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  function automatic logic [31:0] snapshot();
    return {3'b000, vid.rgb_valid, vid.rgb_hsync, vid.rgb_vsync, vid.r, vid.g, vid.b,
            busy, frame_done};
  endfunction

  // Walks one frame from its first pixel cycle, checking timing every cycle
  // and storing every valid pixel. Optional mid-frame pattern change and a
  // continuous clear that also fires a (to be ignored) start pulse.
  task automatic capture_frame(input int slot, input int chg_at, input logic [1:0] chg_pat,
                               input int clr_at);
    int errs;
    int beat, ph, lpos, line;
    logic e_hs, e_vs, e_val, e_fd;
    logic [23:0] pix;
    errs = 0;
    for (int c = 0; c < FRAME_BEATS * DIV; c++) begin
      if (c == chg_at) pattern_sel = chg_pat;
      if (c == clr_at) continuous = 1'b0;
      start = (c == clr_at);
      beat  = c / DIV;
      ph    = c % DIV;
      lpos  = beat % HT;
      line  = beat / HT;
      e_hs  = (line < VA) && (lpos < HA);
      e_vs  = (line < VA);
      e_val = e_hs && (ph == 0);
      e_fd  = (beat == FRAME_BEATS - 1) && (ph == 0);
      pix   = {vid.r, vid.g, vid.b};
      if (vid.rgb_hsync !== e_hs || vid.rgb_vsync !== e_vs || vid.rgb_valid !== e_val ||
          frame_done !== e_fd || busy !== 1'b1)
        errs++;
      if (!e_val && pix !== 24'h0) errs++;
      if (e_val) cap[slot][line*HA + lpos] = pix;
      tick();
    end
    start = 1'b0;
    check($sformatf("timing frame slot%0d", slot), errs, 0);
  endtask

  task automatic run_frame(input int slot, input logic [1:0] pat);
    pattern_sel = pat;
    continuous  = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    capture_frame(slot, -1, 2'd0, -1);
    check($sformatf("idle after slot%0d", slot), {busy, vid.rgb_vsync}, 0);
  endtask

  initial begin
    rst_p       = 1'b1;
    start       = 1'b0;
    continuous  = 1'b0;
    pattern_sel = 2'd0;

    // slot 0 ramp, 1 bars, 2 checker, 3 edge, 4/5 continuous, 6 after reset
    vecs.push_back('{0, 0, 0, 24'h000000});
    vecs.push_back('{0, 15, 0, 24'h0F0F0F});
    vecs.push_back('{0, 7, 3, 24'h070707});
    vecs.push_back('{1, 0, 0, 24'hFFFFFF});
    vecs.push_back('{1, 1, 0, 24'hFFFFFF});
    vecs.push_back('{1, 2, 1, 24'hFFFF00});
    vecs.push_back('{1, 5, 2, 24'h00FFFF});
    vecs.push_back('{1, 6, 0, 24'h00FF00});
    vecs.push_back('{1, 8, 0, 24'hFF00FF});
    vecs.push_back('{1, 11, 3, 24'hFF0000});
    vecs.push_back('{1, 12, 0, 24'h0000FF});
    vecs.push_back('{1, 14, 0, 24'h000000});
    vecs.push_back('{1, 15, 3, 24'h000000});
    vecs.push_back('{2, 0, 0, 24'h000000});
    vecs.push_back('{2, 2, 0, 24'hFFFFFF});
    vecs.push_back('{2, 0, 2, 24'hFFFFFF});
    vecs.push_back('{2, 2, 2, 24'h000000});
    vecs.push_back('{2, 6, 0, 24'hFFFFFF});
    vecs.push_back('{2, 3, 3, 24'h000000});
    vecs.push_back('{3, 7, 0, 24'h000000});
    vecs.push_back('{3, 8, 0, 24'hFFFFFF});
    vecs.push_back('{3, 0, 3, 24'h000000});
    vecs.push_back('{3, 15, 3, 24'hFFFFFF});
    vecs.push_back('{4, 3, 0, 24'h000000});
    vecs.push_back('{4, 7, 2, 24'h000000});
    vecs.push_back('{4, 8, 3, 24'hFFFFFF});
    vecs.push_back('{5, 9, 1, 24'h090909});
    vecs.push_back('{5, 15, 3, 24'h0F0F0F});
    vecs.push_back('{6, 0, 0, 24'h000000});
    vecs.push_back('{6, 5, 0, 24'h050505});

    for (int s = 0; s < 7; s++)
      for (int p = 0; p < HA*VA; p++)
        cap[s][p] = 24'h123456;

    tick();
    tick();
    check("reset state", snapshot(), 0);
    rst_p = 1'b0;
    tick();
    tick();
    check("idle after reset release", snapshot(), 0);

    run_frame(0, 2'd1);
    tick();
    tick();
    check("still idle after ramp", {busy, vid.rgb_valid}, 0);
    run_frame(1, 2'd0);
    run_frame(2, 2'd2);
    run_frame(3, 2'd3);

    // Continuous: pattern changes mid frame 0, takes effect on frame 1
    pattern_sel = 2'd3;
    continuous  = 1'b1;
    start       = 1'b1;
    tick();
    start = 1'b0;
    capture_frame(4, 30 * DIV, 2'd1, -1);
    capture_frame(5, -1, 2'd0, 10 * DIV);
    check("idle after continuous cleared", {busy, vid.rgb_vsync}, 0);

    // Reset at pixel 5 of line 2
    pattern_sel = 2'd1;
    continuous  = 1'b0;
    start       = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < (2*HT + 5) * DIV; c++) tick();
    check("pixel before reset", {vid.rgb_hsync, vid.r}, {1'b1, 8'h05});
    rst_p = 1'b1;
    #1;
    check("async reset clears outputs", snapshot(), 0);
    tick();
    tick();
    rst_p = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start at reset release ignored", snapshot(), 0);
    tick();
    run_frame(6, 2'd1);

    foreach (vecs[i])
      check($sformatf("pixel slot%0d (%0d,%0d)", vecs[i].slot, vecs[i].x, vecs[i].y),
            {8'h00, cap[vecs[i].slot][vecs[i].y*HA + vecs[i].x]}, {8'h00, vecs[i].rgb});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
